bp_me_wormhole_packet_adapter: RTL

Parametrised, bidirectional endpoint adapter between a wide LCE/CCE message interface and one wormhole router port. TX side serialises a variable-length packet (header on LSB: x, y, len) into flits. RX side reassembles incoming flits into a payload. Intended as the common endpoint for all ME network channels (request, command, data command, response), replacing per-channel fixed-length adapter pairs.

---
 rtl/bp_me_wormhole_packet_adapter.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_me_wormhole_packet_adapter.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_packet_adapter
//
// Bidirectional endpoint between a wide ME message interface and one
// wormhole router port. Common to every ME network channel.
//
//   TX: a message (dest x/y, len, payload) is packed into the image
//       {payload, len, y, x} (x at bit 0, zero-padded to a whole number of
//       flits) and sent flit by flit, header flit first.
//   RX: incoming flits are reassembled into the same image. The payload is
//       held on payload_o/v_o until the consumer pulses yumi_i.
//
// Ports
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   dest_x_i, dest_y_i        TX destination coordinates
//   pkt_len_i                 TX flit count minus one (header excluded)
//   payload_i, v_i, ready_o   TX message handshake (valid/ready)
//   link_data_o, link_v_o,
//   link_ready_i              flits towards the router (valid/ready)
//   link_data_i, link_v_i,
//   link_ready_o              flits from the router (valid/ready)
//   payload_o, len_o, v_o,
//   yumi_i                    RX delivery (valid/yumi)
//   err_o                     sticky: an RX packet was longer than fits
//
// Build option
//   BP_ME_WH_ADAPTER_RX_DBUF_EN  ping-pong RX buffers: a second packet can
//                                be received while the first awaits yumi_i.
// ---------------------------------------------------------------------------
module bp_me_wormhole_packet_adapter #(
  parameter int payload_width_p = 536,
  parameter int flit_width_p    = 64,
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int len_width_p     = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [x_cord_width_p-1:0]  dest_x_i,
  input  logic [y_cord_width_p-1:0]  dest_y_i,
  input  logic [len_width_p-1:0]     pkt_len_i,
  input  logic [payload_width_p-1:0] payload_i,
  input  logic                       v_i,
  output logic                       ready_o,

  output logic [flit_width_p-1:0]    link_data_o,
  output logic                       link_v_o,
  input  logic                       link_ready_i,

  input  logic [flit_width_p-1:0]    link_data_i,
  input  logic                       link_v_i,
  output logic                       link_ready_o,

  output logic [payload_width_p-1:0] payload_o,
  output logic [len_width_p-1:0]     len_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic                       err_o
);

  localparam int header_width_lp = x_cord_width_p + y_cord_width_p + len_width_p;
  localparam int max_num_flit_lp =
    (header_width_lp + payload_width_p + flit_width_p - 1) / flit_width_p;
  localparam int image_width_lp  = max_num_flit_lp * flit_width_p;
  localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_num_flit_lp - 1);
  localparam logic [len_width_p-1:0] one_lp     = len_width_p'(1);

  if ((max_num_flit_lp - 1) >= (1 << len_width_p)) begin : g_len_width_check
    $error("len_width_p cannot encode max_num_flit_lp-1");
  end

  // -------------------------------------------------------------------------
  // TX
  // -------------------------------------------------------------------------
  localparam logic [0:0] tx_idle_s = 1'b0;
  localparam logic [0:0] tx_send_s = 1'b1;

  logic [0:0]                tx_state_r;
  logic [len_width_p-1:0]    tx_cnt_r;
  logic [len_width_p-1:0]    tx_len_r;
  logic [image_width_lp-1:0] tx_image_r;
  logic [len_width_p-1:0]    tx_len_clamped;
  logic [flit_width_p-1:0]   tx_flit;
  logic                      tx_last;
  logic                      tx_accept;

  // An out-of-range length would walk past the image; send the maximum.
  assign tx_len_clamped = (pkt_len_i > max_len_lp) ? max_len_lp : pkt_len_i;

  // The final handshake frees the image register, so a new message can be
  // taken in the same cycle and flits continue without a bubble.
  assign tx_last   = (tx_state_r == tx_send_s) && link_ready_i && (tx_cnt_r == tx_len_r);
  assign ready_o   = (tx_state_r == tx_idle_s) || tx_last;
  assign tx_accept = v_i && ready_o;
  assign link_v_o  = (tx_state_r == tx_send_s);

  // NOTE: every variable driven in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    tx_flit = '0;
    for (int k = 0; k < max_num_flit_lp; k++) begin
      if (tx_cnt_r == len_width_p'(k)) begin
        tx_flit = tx_image_r[k*flit_width_p +: flit_width_p];
      end
    end
  end

  assign link_data_o = link_v_o ? tx_flit : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tx_state_r <= tx_idle_s;
      tx_cnt_r   <= '0;
      tx_len_r   <= '0;
    end else if (tx_accept) begin
      tx_state_r <= tx_send_s;
      tx_cnt_r   <= '0;
      tx_len_r   <= tx_len_clamped;
    end else if (tx_last) begin
      tx_state_r <= tx_idle_s;
    end else if (link_v_o && link_ready_i) begin
      tx_cnt_r   <= tx_cnt_r + one_lp;
    end
  end

  // NOTE: wide data registers are not reset; they are only observable
  // through outputs gated by a reset valid bit.
  always_ff @(posedge clk_i) begin
    if (tx_accept) begin
      tx_image_r <= image_width_lp'({payload_i, tx_len_clamped, dest_y_i, dest_x_i});
    end
  end

  // -------------------------------------------------------------------------
  // RX control
  // -------------------------------------------------------------------------
  localparam logic [1:0] rx_hdr_s  = 2'd0;
  localparam logic [1:0] rx_body_s = 2'd1;
  localparam logic [1:0] rx_hold_s = 2'd2;

`ifdef BP_ME_WH_ADAPTER_RX_DBUF_EN
  // Completed packets park in a buffer, the assembler goes back to HDR.
  localparam logic [1:0] rx_done_s = rx_hdr_s;
`else
  localparam logic [1:0] rx_done_s = rx_hold_s;
`endif

  logic [1:0]                rx_state_r;
  logic [len_width_p-1:0]    rx_cnt_r;   // index of the next body flit
  logic [len_width_p-1:0]    rx_len_r;   // len of the packet being assembled
  logic                      rx_err_r;
  logic [len_width_p-1:0]    hdr_len;
  logic                      rx_accept;
  logic                      rx_last;
  logic [image_width_lp-1:0] rx_out_buf;
  logic [len_width_p-1:0]    rx_out_len;

  assign hdr_len   = link_data_i[x_cord_width_p + y_cord_width_p +: len_width_p];
  assign rx_accept = link_v_i && link_ready_o;
  assign rx_last   = rx_accept
                  && (((rx_state_r == rx_hdr_s)  && (hdr_len == '0))
                   || ((rx_state_r == rx_body_s) && (rx_cnt_r == rx_len_r)));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_state_r <= rx_hdr_s;
      rx_cnt_r   <= '0;
      rx_len_r   <= '0;
      rx_err_r   <= 1'b0;
    end else begin
      case (rx_state_r)
        rx_hdr_s: if (rx_accept) begin
          rx_len_r   <= hdr_len;
          rx_cnt_r   <= one_lp;
          rx_state_r <= rx_last ? rx_done_s : rx_body_s;
          // Flits beyond the image will be consumed and dropped.
          if (hdr_len > max_len_lp) rx_err_r <= 1'b1;
        end
        rx_body_s: if (rx_accept) begin
          rx_cnt_r <= rx_cnt_r + one_lp;
          if (rx_last) rx_state_r <= rx_done_s;
        end
        rx_hold_s: if (yumi_i) rx_state_r <= rx_hdr_s;
        default: rx_state_r <= rx_hdr_s;
      endcase
    end
  end

  assign err_o = rx_err_r;

  // -------------------------------------------------------------------------
  // RX storage
  // -------------------------------------------------------------------------
`ifdef BP_ME_WH_ADAPTER_RX_DBUF_EN
  logic [image_width_lp-1:0] rx_buf_r  [2];
  logic [len_width_p-1:0]    rx_blen_r [2];
  logic [1:0]                rx_full_r;
  logic                      rx_wr_r;
  logic                      rx_rd_r;

  // Assembly only targets a free buffer; both full is the only stall.
  assign link_ready_o = !rx_full_r[rx_wr_r];
  assign v_o          = rx_full_r[rx_rd_r];
  assign rx_out_buf   = rx_buf_r[rx_rd_r];
  assign rx_out_len   = rx_blen_r[rx_rd_r];

  // A same-cycle fill and drain always touch different buffers: the write
  // buffer is empty and the read buffer is full.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_full_r <= '0;
      rx_wr_r   <= 1'b0;
      rx_rd_r   <= 1'b0;
    end else begin
      if (rx_last) begin
        rx_full_r[rx_wr_r] <= 1'b1;
        rx_wr_r            <= ~rx_wr_r;
      end
      if (v_o && yumi_i) begin
        rx_full_r[rx_rd_r] <= 1'b0;
        rx_rd_r            <= ~rx_rd_r;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_accept) begin
      if (rx_state_r == rx_hdr_s) begin
        rx_buf_r[rx_wr_r]  <= image_width_lp'(link_data_i);
        rx_blen_r[rx_wr_r] <= hdr_len;
      end else begin
        for (int k = 1; k < max_num_flit_lp; k++) begin
          if (rx_cnt_r == len_width_p'(k)) begin
            rx_buf_r[rx_wr_r][k*flit_width_p +: flit_width_p] <= link_data_i;
          end
        end
      end
    end
  end
`else
  logic [image_width_lp-1:0] rx_buf_r;

  assign link_ready_o = (rx_state_r != rx_hold_s);
  assign v_o          = (rx_state_r == rx_hold_s);
  assign rx_out_buf   = rx_buf_r;
  assign rx_out_len   = rx_len_r;

  // The header write clears the whole image, so flits never received read 0.
  always_ff @(posedge clk_i) begin
    if (rx_accept) begin
      if (rx_state_r == rx_hdr_s) begin
        rx_buf_r <= image_width_lp'(link_data_i);
      end else begin
        for (int k = 1; k < max_num_flit_lp; k++) begin
          if (rx_cnt_r == len_width_p'(k)) begin
            rx_buf_r[k*flit_width_p +: flit_width_p] <= link_data_i;
          end
        end
      end
    end
  end
`endif

  assign payload_o = v_o ? rx_out_buf[header_width_lp +: payload_width_p] : '0;
  assign len_o     = v_o ? rx_out_len : '0;

endmodule
